// File: rtl/sbox_sched_pkg.sv
// Shared types for the masked S-box issue scheduler.
// FSM state codes and the pipeline tracking entry.
package sbox_sched_pkg;

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_HALT  = 2'd2;

  // Package types cannot follow module parameters, so owner
  // and tag are held at a ceiling width and narrowed by the user.
  localparam int OWN_W   = 8;
  localparam int TAG_MAX = 16;

  typedef struct packed {
    logic               valid;
    logic [OWN_W-1:0]   owner;
    logic [TAG_MAX-1:0] tag;
  } entry_t;

endpackage

// File: rtl/sbox_sched_arb.sv
// Requester arbiter: one-hot grant plus encoded select.
// Ports: clk/rst_n (pointer build only), req, gnt, sel, any.
// SBOX_SCHED_RR_EN selects round-robin, else fixed priority.
module sbox_sched_arb #(
  parameter int NREQ  = 2,
  parameter int SEL_W = 1
) (
`ifdef SBOX_SCHED_RR_EN
  input  logic             clk,
  input  logic             rst_n,
`endif
  input  logic [NREQ-1:0]  req,
  output logic [NREQ-1:0]  gnt,
  output logic [SEL_W-1:0] sel,
  output logic             any
);

  logic [SEL_W-1:0]  ptr;
  logic [2*NREQ-1:0] rot;

`ifdef SBOX_SCHED_RR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (any) begin
      if (sel == SEL_W'(NREQ-1)) ptr <= '0;
      else ptr <= sel + 1'b1;
    end
  end
`else
  assign ptr = '0;
`endif

  // Rotate so the pointer position is bit 0; the lowest set
  // bit after rotation is the winner.
  always_comb begin
    rot = {req, req} >> ptr;
    any = |req;
    sel = '0;
    for (int k = NREQ-1; k >= 0; k--) begin
      if (rot[k]) sel = SEL_W'((int'(ptr) + k) % NREQ);
    end
    for (int j = 0; j < NREQ; j++) begin
      gnt[j] = any && (sel == SEL_W'(j));
    end
  end

endmodule

// File: rtl/sbox_sched.sv
// Issue scheduler for a shared masked S-box with LAT-cycle latency.
// Ports: req_valid_i/req_tag_i/req_ready_o, prng_ready_i, quiesce_i,
// flush_i, sel_o, issue_o, rsp_valid_o, rsp_tag_o, inflight_o, idle_o.
// Build option SBOX_SCHED_RR_EN: round-robin arbitration.
module sbox_sched
  import sbox_sched_pkg::*;
#(
  parameter int LAT   = 4,
  parameter int NREQ  = 2,
  parameter int TAG_W = 2,
  localparam int SEL_W = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int CNT_W = $clog2(LAT+1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid_i,
  input  logic [NREQ*TAG_W-1:0] req_tag_i,
  output logic [NREQ-1:0]   req_ready_o,
  input  logic              prng_ready_i,
  input  logic              quiesce_i,
  input  logic              flush_i,
  output logic [SEL_W-1:0]  sel_o,
  output logic              issue_o,
  output logic [NREQ-1:0]   rsp_valid_o,
  output logic [TAG_W-1:0]  rsp_tag_o,
  output logic [CNT_W-1:0]  inflight_o,
  output logic              idle_o
);

  logic [1:0]       state;
  logic [1:0]       state_nx;
  entry_t           pipe [LAT];
  entry_t           ent_in;
  entry_t           last;
  logic             en;
  logic             any;
  logic             live_nx;
  logic             empty_nx;
  logic [NREQ-1:0]  gnt;
  logic [SEL_W-1:0] sel;
  logic [CNT_W-1:0] cnt;

  // Gating on rst_n keeps the combinational grant low in reset.
  assign en = rst_n && prng_ready_i && !flush_i
           && (state == ST_RUN);

  sbox_sched_arb #(
    .NREQ  (NREQ),
    .SEL_W (SEL_W)
  ) u_arb (
`ifdef SBOX_SCHED_RR_EN
    .clk   (clk),
    .rst_n (rst_n),
`endif
    .req   (req_valid_i & {NREQ{en}}),
    .gnt   (gnt),
    .sel   (sel),
    .any   (any)
  );

  assign req_ready_o = gnt;
  assign sel_o       = sel;
  assign issue_o     = any;

  always_comb begin
    ent_in       = '0;
    ent_in.valid = any;
    ent_in.owner = OWN_W'(sel);
    ent_in.tag   = TAG_MAX'(req_tag_i[sel*TAG_W +: TAG_W]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) pipe[i] <= '0;
    end else begin
      for (int i = LAT-1; i > 0; i--) begin
        pipe[i]       <= pipe[i-1];
        pipe[i].valid <= pipe[i-1].valid & ~flush_i;
      end
      pipe[0]       <= ent_in;
      pipe[0].valid <= ent_in.valid & ~flush_i;
    end
  end

  // live_nx: something survives the coming edge (the last
  // stage retires at it, so it is excluded).
  always_comb begin
    cnt     = '0;
    live_nx = 1'b0;
    for (int i = 0; i < LAT; i++) begin
      cnt = cnt + CNT_W'(pipe[i].valid);
    end
    for (int i = 0; i < LAT-1; i++) begin
      live_nx = live_nx | pipe[i].valid;
    end
  end

  assign empty_nx   = !live_nx && !any;
  assign inflight_o = cnt;

  // HALT is entered at the edge after which nothing is in flight,
  // so idle rises the cycle after the final response.
  always_comb begin
    state_nx = state;
    unique case (1'b1)
      (state == ST_RUN): begin
        if (quiesce_i) state_nx = empty_nx ? ST_HALT : ST_DRAIN;
      end
      (state == ST_DRAIN): begin
        if (!quiesce_i) state_nx = ST_RUN;
        else if (empty_nx) state_nx = ST_HALT;
      end
      (state == ST_HALT): begin
        if (!quiesce_i) state_nx = ST_RUN;
      end
      default: state_nx = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_RUN;
    else state <= state_nx;
  end

  assign last   = pipe[LAT-1];
  assign idle_o = (state == ST_HALT);

  always_comb begin
    rsp_tag_o = last.valid ? last.tag[TAG_W-1:0] : '0;
    for (int j = 0; j < NREQ; j++) begin
      rsp_valid_o[j] = last.valid && (last.owner == OWN_W'(j));
    end
  end

endmodule

// File: tb/tb_sbox_sched.sv
// Self-checking bench for sbox_sched.
// Cycle-schedule reference model plus directed scenarios.
module tb_sbox_sched;

  localparam int LAT   = 4;
  localparam int NREQ  = 2;
  localparam int TAG_W = 2;
  localparam int SEL_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNT_W = $clog2(LAT+1);
  localparam int VW    = 2*NREQ + SEL_W + 1 + TAG_W + CNT_W + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NREQ-1:0] req_valid_i = '0;
  logic [NREQ*TAG_W-1:0] req_tag_i = '0;
  logic prng_ready_i = 1'b0;
  logic quiesce_i = 1'b0;
  logic flush_i = 1'b0;
  logic [NREQ-1:0] req_ready_o;
  logic [SEL_W-1:0] sel_o;
  logic issue_o;
  logic [NREQ-1:0] rsp_valid_o;
  logic [TAG_W-1:0] rsp_tag_o;
  logic [CNT_W-1:0] inflight_o;
  logic idle_o;

  always #5 clk = ~clk;

  sbox_sched #(.LAT(LAT), .NREQ(NREQ), .TAG_W(TAG_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid_i  (req_valid_i),
    .req_tag_i    (req_tag_i),
    .req_ready_o  (req_ready_o),
    .prng_ready_i (prng_ready_i),
    .quiesce_i    (quiesce_i),
    .flush_i      (flush_i),
    .sel_o        (sel_o),
    .issue_o      (issue_o),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_tag_o    (rsp_tag_o),
    .inflight_o   (inflight_o),
    .idle_o       (idle_o)
  );

  wire [VW-1:0] obs = {req_ready_o, sel_o, issue_o, rsp_valid_o,
                       rsp_tag_o, inflight_o, idle_o};
  logic [VW-1:0] exp_v;

  int ncmp = 0;
  int nerr = 0;
  int t = 0;
  int g = -1;
  int mst = 0;
  int mptr = 0;
  int s_own[int];
  int s_tag[int];

  // Model: responses are scheduled by absolute cycle number.
  task automatic model_eval();
    logic [NREQ-1:0] rdy, rv;
    logic [SEL_W-1:0] sl;
    logic [TAG_W-1:0] tg;
    int n;
    rdy = '0; rv = '0; sl = '0; tg = '0; n = 0; g = -1;
    if (prng_ready_i && mst == 0 && !flush_i && rst_n) begin
      for (int k = 0; k < NREQ; k++) begin
`ifdef SBOX_SCHED_RR_EN
        int i = (mptr + k) % NREQ;
`else
        int i = k;
`endif
        if (g < 0 && req_valid_i[i]) g = i;
      end
      if (g >= 0) begin
        rdy[g] = 1'b1;
        sl = SEL_W'(g);
      end
    end
    if (s_own.exists(t)) begin
      rv[s_own[t]] = 1'b1;
      tg = TAG_W'(s_tag[t]);
    end
    foreach (s_own[k]) if (k >= t && k <= t + LAT - 1) n++;
    if (!rst_n) exp_v = '0;
    else exp_v = {rdy, sl, (g >= 0), rv, tg, CNT_W'(n), (mst == 2)};
  endtask

  task automatic model_adv();
    bit empty;
    int kill[$];
    if (!rst_n) begin
      s_own.delete(); s_tag.delete();
      mst = 0; mptr = 0;
    end else begin
      if (g >= 0) begin
        s_own[t+LAT] = g;
        s_tag[t+LAT] = int'(req_tag_i[g*TAG_W +: TAG_W]);
        mptr = (g + 1) % NREQ;
      end
      empty = 1'b1;
      foreach (s_own[k]) if (k > t && k <= t + LAT) empty = 1'b0;
      if (flush_i) begin
        foreach (s_own[k]) if (k > t) kill.push_back(k);
        foreach (kill[i]) begin
          s_own.delete(kill[i]);
          s_tag.delete(kill[i]);
        end
      end
      case (mst)
        0: if (quiesce_i) mst = empty ? 2 : 1;
        1: if (!quiesce_i) mst = 0; else if (empty) mst = 2;
        default: if (!quiesce_i) mst = 0;
      endcase
    end
    t++;
  endtask

  task automatic drive(input logic r, input logic [NREQ-1:0] v,
                       input logic [NREQ*TAG_W-1:0] tg,
                       input logic p, input logic q, input logic f);
    @(negedge clk);
    rst_n = r; req_valid_i = v; req_tag_i = tg;
    prng_ready_i = p; quiesce_i = q; flush_i = f;
    #1;
    model_eval();
  endtask

  task automatic do_reset();
    for (int c = 0; c < 2; c++) begin
      drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
      model_adv();
    end
  endtask

  task automatic test_reset();
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, 2'b11, 4'hF, 1'b1, 1'b0, 1'b0);
      ncmp++;
      if (obs !== exp_v) begin
        nerr++;
        $display("FAIL reset c=%0d got=%h want=%h", c, obs, exp_v);
      end
      ncmp++;
      if (req_ready_o !== 2'b00 || issue_o !== 1'b0) begin
        nerr++;
        $display("FAIL reset_grant c=%0d got=%b/%b want=00/0",
                 c, req_ready_o, issue_o);
      end
      model_adv();
    end
  endtask

  task automatic test_single();
    do_reset();
    for (int c = 0; c < 17; c++) begin
      drive(1'b1, (c == 10) ? 2'b01 : 2'b00, 4'b0011,
            1'b1, 1'b0, 1'b0);
      ncmp++;
      if (obs !== exp_v) begin
        nerr++;
        $display("FAIL single c=%0d got=%h want=%h", c, obs, exp_v);
      end
      if (c == 14) begin
        ncmp++;
        if (rsp_valid_o !== 2'b01 || rsp_tag_o !== 2'd3) begin
          nerr++;
          $display("FAIL single_rsp got=%b/%0d want=01/3",
                   rsp_valid_o, rsp_tag_o);
        end
      end
      model_adv();
    end
  endtask

  task automatic test_contention();
    int expg[4];
    logic [1:0] oh;
`ifdef SBOX_SCHED_RR_EN
    expg = '{0, 1, 0, 1};
`else
    expg = '{0, 0, 0, 0};
`endif
    do_reset();
    for (int c = 0; c < 10; c++) begin
      drive(1'b1, (c < 4) ? 2'b11 : 2'b00,
            {TAG_W'(c ^ 3), TAG_W'(c)}, 1'b1, 1'b0, 1'b0);
      ncmp++;
      if (obs !== exp_v) begin
        nerr++;
        $display("FAIL contend c=%0d got=%h want=%h", c, obs, exp_v);
      end
      if (c < 4) begin
        ncmp++;
        if (issue_o !== 1'b1 || sel_o !== SEL_W'(expg[c])) begin
          nerr++;
          $display("FAIL contend_gnt c=%0d got=%0d want=%0d",
                   c, sel_o, expg[c]);
        end
      end else if (c < 8) begin
        oh = 2'b01 << expg[c-4];
        ncmp++;
        if (rsp_valid_o !== oh) begin
          nerr++;
          $display("FAIL contend_rsp c=%0d got=%b want=%b",
                   c, rsp_valid_o, oh);
        end
      end
      model_adv();
    end
  endtask

  task automatic test_prng();
    do_reset();
    for (int c = 0; c < 11; c++) begin
      drive(1'b1, (c < 6) ? 2'b11 : 2'b00, 4'b1001,
            (c >= 5), 1'b0, 1'b0);
      ncmp++;
      if (obs !== exp_v) begin
        nerr++;
        $display("FAIL prng c=%0d got=%h want=%h", c, obs, exp_v);
      end
      if (c < 5) begin
        ncmp++;
        if (req_ready_o !== 2'b00 || issue_o !== 1'b0) begin
          nerr++;
          $display("FAIL prng_gate c=%0d got=%b/%b want=00/0",
                   c, req_ready_o, issue_o);
        end
      end else if (c == 5) begin
        ncmp++;
        if (issue_o !== 1'b1) begin
          nerr++;
          $display("FAIL prng_first got=%b want=1", issue_o);
        end
      end
      model_adv();
    end
  endtask

  task automatic test_flush();
    do_reset();
    for (int c = 0; c < 9; c++) begin
      drive(1'b1, (c <= 2) ? 2'b01 : 2'b00, 4'b0110,
            1'b1, 1'b0, (c == 2));
      ncmp++;
      if (obs !== exp_v) begin
        nerr++;
        $display("FAIL flush c=%0d got=%h want=%h", c, obs, exp_v);
      end
      if (c == 2 || c == 3) begin
        ncmp++;
        if (inflight_o !== CNT_W'((c == 2) ? 2 : 0)) begin
          nerr++;
          $display("FAIL flush_cnt c=%0d got=%0d want=%0d",
                   c, inflight_o, (c == 2) ? 2 : 0);
        end
      end
      if (c >= 3 && c <= 6) begin
        ncmp++;
        if (rsp_valid_o !== 2'b00) begin
          nerr++;
          $display("FAIL flush_rsp c=%0d got=%b want=00",
                   c, rsp_valid_o);
        end
      end
      model_adv();
    end
  endtask

  task automatic test_quiesce();
    do_reset();
    for (int c = 0; c < 14; c++) begin
      drive(1'b1, (c == 0 || c >= 7) ? 2'b01 : 2'b00, 4'b0001,
            1'b1, (c >= 1 && c <= 6), 1'b0);
      ncmp++;
      if (obs !== exp_v) begin
        nerr++;
        $display("FAIL quiesce c=%0d got=%h want=%h", c, obs, exp_v);
      end
      if (c == 4 || c == 5 || c == 7 || c == 8) begin
        ncmp++;
        if ((c == 4 && rsp_valid_o !== 2'b01) ||
            (c == 5 && idle_o !== 1'b1) ||
            (c == 7 && issue_o !== 1'b0) ||
            (c == 8 && issue_o !== 1'b1)) begin
          nerr++;
          $display("FAIL quiesce_pt c=%0d got rsp=%b idle=%b iss=%b",
                   c, rsp_valid_o, idle_o, issue_o);
        end
      end
      model_adv();
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int c = 0; c < 10; c++) begin
      drive((c != 2), (c == 0) ? 2'b01 : (c == 1) ? 2'b10 : 2'b00,
            4'b1011, 1'b1, 1'b0, 1'b0);
      ncmp++;
      if (obs !== exp_v) begin
        nerr++;
        $display("FAIL rstmid c=%0d got=%h want=%h", c, obs, exp_v);
      end
      if (c >= 2) begin
        ncmp++;
        if (rsp_valid_o !== 2'b00 ||
            (c == 2 && (inflight_o !== '0 || idle_o !== 1'b0))) begin
          nerr++;
          $display("FAIL rstmid_out c=%0d got rsp=%b cnt=%0d want 0",
                   c, rsp_valid_o, inflight_o);
        end
      end
      model_adv();
    end
  endtask

  task automatic test_random();
    logic q;
    q = 1'b0;
    do_reset();
    for (int c = 0; c < 500; c++) begin
      if ($urandom_range(0, 15) == 0) q = ~q;
      drive(1'b1, NREQ'($urandom), (NREQ*TAG_W)'($urandom),
            ($urandom_range(0, 7) != 0), q,
            ($urandom_range(0, 19) == 0));
      ncmp++;
      if (obs !== exp_v) begin
        nerr++;
        $display("FAIL random c=%0d got=%h want=%h", c, obs, exp_v);
      end
      model_adv();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_prng();
    test_flush();
    test_quiesce();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/sbox_sched.md
SBOX_SCHED -- requirements
Module: sbox_sched

Interface
REQ-001 SHALL have parameter LAT, default 4, meaning masked S-box pipeline latency in cycles.
REQ-002 SHALL have parameter NREQ, default 2, meaning number of requesters sharing the S-box.
REQ-003 SHALL have parameter TAG_W, default 2, meaning requester-defined tag width carried alongside each operand.
REQ-004 SHALL have port clk, input, 1, the single clock.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port req_valid_i, input, NREQ, per-requester operand valid.
REQ-007 SHALL have port req_tag_i, input, NREQ*TAG_W, per-requester tag, requester i at bits [i*TAG_W +: TAG_W].
REQ-008 SHALL have port req_ready_o, output, NREQ, one-hot grant; a transfer occurs when valid and ready are both high.
REQ-009 SHALL have port prng_ready_i, input, 1, high when the PRNG guarantees fresh randomness on all S-box stages for the next LAT cycles.
REQ-010 SHALL have port quiesce_i, input, 1, stop-issue request used before PRNG reseed.
REQ-011 SHALL have port flush_i, input, 1, kill all in-flight operations.
REQ-012 SHALL have port sel_o, output, max(1,$clog2(NREQ)), S-box input mux select.
REQ-013 SHALL have port issue_o, output, 1, high in the cycle an operand enters the S-box.
REQ-014 SHALL have port rsp_valid_o, output, NREQ, one-hot: the S-box output belongs to requester i.
REQ-015 SHALL have port rsp_tag_o, output, TAG_W, tag of the current response.
REQ-016 SHALL have port inflight_o, output, $clog2(LAT+1), number of live entries in flight.
REQ-017 SHALL have port idle_o, output, 1, high in HALT state.

Function
REQ-018 SHALL grant at most one requester per cycle, only when prng_ready_i=1, state=RUN and flush_i=0.
REQ-019 SHALL drive req_ready_o, sel_o and issue_o combinationally in the grant cycle; sel_o is the granted index, or 0 with issue_o=0.
REQ-020 SHALL track each issue in a LAT-deep shift register of {valid, owner, tag} entries that advances every cycle unconditionally.
REQ-021 SHALL assert rsp_valid_o[owner] and rsp_tag_o exactly LAT cycles after the issue cycle; rsp_tag_o is 0 when no response is pending.
REQ-022 SHALL keep inflight_o equal to the count of valid entries, counting an issue and a retirement in the same cycle as a net change of 0.
REQ-023 SHALL clear all entry valid bits at the clock edge ending a flush_i=1 cycle, so no responses appear in the following LAT cycles; a response already presented in the flush cycle is still delivered.
REQ-024 SHALL implement FSM RUN->DRAIN on quiesce_i=1; DRAIN->HALT when inflight_o=0; HALT->RUN on quiesce_i=0; DRAIN->RUN on quiesce_i=0 before empty.
REQ-025 SHALL go RUN->HALT directly when quiesce_i=1 and inflight_o=0.
REQ-026 SHALL issue no operand in DRAIN or HALT.
REQ-027 SHALL accept flush_i in any state without changing state, except that the resulting empty pipeline lets DRAIN->HALT on the next cycle.

Reset
REQ-028 SHALL, while rst_n=0, clear all entries, set state RUN, round-robin pointer 0, and drive every output to 0.
REQ-029 SHALL discard any operation in flight when reset is asserted mid-operation, with no response after reset release.

Configuration
REQ-030 SHALL, with SBOX_SCHED_RR_EN defined, arbitrate round-robin: the pointer moves to one past the last granted index after each grant.
REQ-031 SHALL, without SBOX_SCHED_RR_EN, arbitrate fixed-priority with index 0 highest and implement no pointer register.

Structure
REQ-032 SHALL place state encoding (RUN, DRAIN, HALT) and the pipeline entry struct in shared package sbox_sched_pkg.
REQ-033 SHALL implement arbitration in sub-module sbox_sched_arb.

Verification
REQ-034 SHALL check single issue: req_valid_i=01, tag 2'b11 at cycle 10 -> rsp_valid_o=01, rsp_tag_o=3 at cycle 14.
REQ-035 SHALL check contention with RR: both valid for 4 cycles -> grants 0,1,0,1 (RR) or 0,0,0,0 (fixed), with responses in the same order 4 cycles later.
REQ-036 SHALL check PRNG gating: prng_ready_i=0 with requests pending -> req_ready_o=0 and issue_o=0 throughout; the first grant comes in the cycle prng_ready_i rises.
REQ-037 SHALL check flush: issue at cycles 0,1,2 and flush_i at cycle 2 -> no rsp_valid_o in cycles 3..6 and inflight_o=0 at cycle 3.
REQ-038 SHALL check quiesce: issue at 0, quiesce_i=1 at 1 -> DRAIN, response at 4, idle_o=1 at 5; quiesce_i=0 -> grants resume the next cycle.
REQ-039 SHALL check reset: rst_n low at cycle 2 with 2 entries in flight -> all outputs 0, and no rsp_valid_o after release.
